// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, ALU opcodes and arbiter state encoding
//
// Purpose : constants shared by the ALU arbiter slice.
// Contents: OPW/AW/BW/RW default widths, ALU opcode constants,
//           IDLE/EXEC/RESP state encoding, latency counter width.
package alu_pkg;

    localparam int OPW  = 3;
    localparam int AW   = 8;
    localparam int BW   = 10;
    localparam int RW   = 10;

    // Latency counter holds ALU_LATENCY, legal range 1..7.
    localparam int CNTW = 3;

    localparam logic [OPW-1:0] OP_NOP = 3'd0;
    localparam logic [OPW-1:0] OP_ADD = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with pointer update on accept
//
// Purpose : picks one of two requesters; a lone valid port always wins,
//           a tie goes to the port named by the round-robin pointer.
// Ports   : clk, rst    - clock, synchronous active-high reset
//           valid[1:0]  - request present per port
//           enable      - arbiter may accept this cycle
//           ready[1:0]  - one-hot accept strobe (never both set)
//           grant       - index of the winning port
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] ready,
    output logic       grant
);

    logic rr_ptr;

    always_comb begin
        grant = (valid == 2'b11) ? rr_ptr : valid[1];
        ready = {enable & valid[1] & grant, enable & valid[0] & ~grant};
    end

    // After an accept the other port is favoured; pointer is untouched
    // while nobody is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (|ready) begin
            rr_ptr <= ~grant;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one pipelined ALU between two requesters
//
// Purpose : round-robin arbitrates port 0 (CPU control) and port 1
//           (datapath master), holds the winning operation on the ALU
//           inputs for ALU_LATENCY+1 cycles, captures out1/flag and
//           returns them to the winner over a valid/ready handshake.
// Ports   : clk, rst                  - clock, synchronous active-high reset
//           reqN_valid/ready          - request handshake, N = 0,1
//           reqN_opcode/a/b           - request payload
//           rspN_valid/ready          - response handshake
//           rspN_result/flag          - captured ALU out1/flag
//           alu_opcode/in1/in2        - to the ALU (0 outside EXEC)
//           alu_out1/flag             - from the ALU
module alu_arbiter #(
    parameter int ALU_LATENCY = 1,
    parameter int OPW         = alu_pkg::OPW,
    parameter int AW          = alu_pkg::AW,
    parameter int BW          = alu_pkg::BW,
    parameter int RW          = alu_pkg::RW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_opcode,
    input  logic [AW-1:0]  req0_a,
    input  logic [BW-1:0]  req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_opcode,
    input  logic [AW-1:0]  req1_a,
    input  logic [BW-1:0]  req1_b,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [RW-1:0]  rsp0_result,
    output logic           rsp0_flag,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [RW-1:0]  rsp1_result,
    output logic           rsp1_flag,
    output logic [OPW-1:0] alu_opcode,
    output logic [AW-1:0]  alu_in1,
    output logic [BW-1:0]  alu_in2,
    input  logic [RW-1:0]  alu_out1,
    input  logic           alu_flag
);

    import alu_pkg::state_t, alu_pkg::ST_IDLE, alu_pkg::ST_EXEC, alu_pkg::ST_RESP,
           alu_pkg::CNTW;

    localparam logic [CNTW-1:0] LAT = CNTW'(ALU_LATENCY);

    state_t          state;
    logic            owner;
    logic [CNTW-1:0] cnt;
    logic [1:0]      rsp_valid;
    logic [RW-1:0]   result_q;
    logic            flag_q;

    logic [1:0]      req_ready;
    logic            grant;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({req1_valid, req0_valid}),
        .enable (state == ST_IDLE),
        .ready  (req_ready),
        .grant  (grant)
    );

    assign req0_ready  = req_ready[0];
    assign req1_ready  = req_ready[1];
    assign rsp0_valid  = rsp_valid[0];
    assign rsp1_valid  = rsp_valid[1];
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_flag   = flag_q;
    assign rsp1_flag   = flag_q;

    // The alu_* registers double as the latched request: loaded on accept,
    // cleared when the result is captured, so the ALU sees a no-op
    // everywhere except EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            cnt        <= '0;
            rsp_valid  <= 2'b00;
            result_q   <= '0;
            flag_q     <= 1'b0;
            alu_opcode <= alu_pkg::OP_NOP;
            alu_in1    <= '0;
            alu_in2    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_ready) begin
                        owner      <= grant;
                        alu_opcode <= grant ? req1_opcode : req0_opcode;
                        alu_in1    <= grant ? req1_a      : req0_a;
                        alu_in2    <= grant ? req1_b      : req0_b;
                        cnt        <= LAT;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        result_q   <= alu_out1;
                        flag_q     <= alu_flag;
                        alu_opcode <= alu_pkg::OP_NOP;
                        alu_in1    <= '0;
                        alu_in2    <= '0;
                        rsp_valid  <= owner ? 2'b10 : 2'b01;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (|(rsp_valid & {rsp1_ready, rsp0_ready})) begin
                        rsp_valid <= 2'b00;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
